// File: rtl/pipelined_addsub_if.sv
// pipelined_addsub_if
//   Handshake and data bundle for pipelined_addsub.
//   Operand side : in_valid, in_ready, a, b, sub
//   Result side  : out_valid, out_ready, sum, cout, ovf, zero, neg
//   Modports     : master = producer of operands / consumer of results
//                  slave  = the adder pipeline itself
interface pipelined_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             neg;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero, neg
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero, neg
  );
endinterface

// File: rtl/pipelined_addsub.sv
// pipelined_addsub
//   Integer add/subtract unit with the carry chain cut into SEG_W-bit
//   segments, one pipeline stage per segment (NSEG = WIDTH/SEG_W stages,
//   latency NSEG, one op per cycle). valid/ready on both sides; the whole
//   pipeline freezes while a result is offered and not taken.
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous, active-high reset
//     bus  - pipelined_addsub_if.slave (operands, result, flags, handshakes)
//   Optional build macro: PIPELINED_ADDSUB_SATURATE_EN
//     defined   -> on signed overflow the result clamps to the signed limit
//                  in the direction of a's sign (ovf still reported)
//     undefined -> result wraps modulo 2^WIDTH
module pipelined_addsub #(
  parameter int WIDTH = 32,
  parameter int SEG_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipelined_addsub_if.slave bus
);
  localparam int SEG_SAFE = (SEG_W > 0) ? SEG_W : 1;
  localparam int NSEG     = WIDTH / SEG_SAFE;

  if ((SEG_W < 1) || (SEG_W > WIDTH) || ((WIDTH % SEG_SAFE) != 0)) begin : g_param_check
    $fatal(1, "pipelined_addsub: WIDTH (%0d) must be a positive multiple of SEG_W (%0d)",
           WIDTH, SEG_W);
  end

  logic stall;
  logic adv;
  logic out_valid_q;

  assign stall       = out_valid_q && !bus.out_ready;
  assign adv         = !stall;
  assign bus.in_ready = adv;

  // Inputs seen by stage k. The accumulator word holds finished sum bits
  // below segment k (de-skew) and still-untouched a bits from segment k up
  // (skew); st_bx carries the conditioned b operand alongside it.
  logic [WIDTH-1:0] st_acc [NSEG];
  logic [WIDTH-1:0] st_bx  [NSEG];
  logic             st_cy  [NSEG];
  logic             st_vld [NSEG];

  // Combinational result of each stage's segment add.
  logic [WIDTH-1:0] acc_nx [NSEG];
  logic             cy_nx  [NSEG];

  assign st_acc[0] = bus.a;
  assign st_bx[0]  = bus.b ^ {WIDTH{bus.sub}};
  assign st_cy[0]  = bus.sub;
  assign st_vld[0] = bus.in_valid;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    logic [SEG_W:0]   seg_sum;
    logic [WIDTH-1:0] acc_l;

    assign seg_sum = {1'b0, st_acc[k][k*SEG_W +: SEG_W]}
                   + {1'b0, st_bx[k][k*SEG_W +: SEG_W]}
                   + {{SEG_W{1'b0}}, st_cy[k]};

    always_comb begin
      acc_l = st_acc[k];
      acc_l[k*SEG_W +: SEG_W] = seg_sum[SEG_W-1:0];
    end

    assign acc_nx[k] = acc_l;
    assign cy_nx[k]  = seg_sum[SEG_W];

    // Every stage except the last registers its partial word and carry;
    // the last stage feeds the output register below.
    if (k < NSEG - 1) begin : g_mid
      logic [WIDTH-1:0] acc_q;
      logic [WIDTH-1:0] bx_q;
      logic             cy_q;
      logic             vld_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          acc_q <= '0;
          bx_q  <= '0;
          cy_q  <= 1'b0;
          vld_q <= 1'b0;
        end else if (adv) begin
          acc_q <= acc_l;
          bx_q  <= st_bx[k];
          cy_q  <= seg_sum[SEG_W];
          vld_q <= st_vld[k];
        end
      end

      assign st_acc[k+1] = acc_q;
      assign st_bx[k+1]  = bx_q;
      assign st_cy[k+1]  = cy_q;
      assign st_vld[k+1] = vld_q;
    end
  end

  // Final stage: the top segment has just been added, so the full result
  // is available. a[MSB] is still sitting untouched in the skew part of the
  // accumulator input and bx[MSB] in the b skew word.
  logic [WIDTH-1:0] raw_sum;
  logic             raw_cout;
  logic             a_msb;
  logic             bx_msb;
  logic             ovf_nx;
  logic [WIDTH-1:0] res_nx;

  assign raw_sum  = acc_nx[NSEG-1];
  assign raw_cout = cy_nx[NSEG-1];
  assign a_msb    = st_acc[NSEG-1][WIDTH-1];
  assign bx_msb   = st_bx[NSEG-1][WIDTH-1];
  assign ovf_nx   = (a_msb == bx_msb) && (raw_sum[WIDTH-1] != a_msb);

`ifdef PIPELINED_ADDSUB_SATURATE_EN
  always_comb begin
    res_nx = raw_sum;
    if (ovf_nx) begin
      res_nx = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign res_nx = raw_sum;
`endif

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;

  // zero/neg are registered rather than decoded from sum_q so that all
  // flags read 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
    end else if (adv) begin
      out_valid_q <= st_vld[NSEG-1];
      sum_q       <= res_nx;
      cout_q      <= raw_cout;
      ovf_q       <= ovf_nx;
      zero_q      <= (res_nx == '0);
      neg_q       <= res_nx[WIDTH-1];
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub
//   Self-checking bench for pipelined_addsub at WIDTH=32, SEG_W=16.
//   A signed/unsigned arithmetic model predicts each accepted operation;
//   a negedge monitor compares every offered result in order, plus
//   directed cases with literal expectations.
module tb_pipelined_addsub;
  localparam int WIDTH = 32;
  localparam int SEG_W = 16;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    logic        neg;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipelined_addsub_if #(.WIDTH(WIDTH)) bus ();

  pipelined_addsub #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  res_t expq[$];
  logic prev_stall = 1'b0;
  logic [31:0] prev_sum = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
    res_t r;
    longint sx, sy, sr;
    logic [32:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sr = s ? sx - sy : sx + sy;
    u = {1'b0, x} + {1'b0, y};
    r.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    r.cout = s ? (x >= y) : u[32];
    r.sum  = sr[31:0];
`ifdef PIPELINED_ADDSUB_SATURATE_EN
    if (r.ovf) r.sum = (sx < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    r.zero = (r.sum == 32'd0);
    r.neg  = r.sum[31];
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  // Monitor: compares every offered result against the model queue.
  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_sum", bus.sum, 0);
      prev_stall = 1'b0;
    end else begin
      chk("in_ready_vs_stall", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      if (prev_stall) begin
        chk("stall_hold_valid", bus.out_valid, 1);
        chk("stall_hold_sum", bus.sum, prev_sum);
      end
      if (bus.out_valid) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got sum %0h expected no result at %0t", bus.sum, $time);
        end else begin
          chk("model_sum",  bus.sum,  expq[0].sum);
          chk("model_cout", bus.cout, expq[0].cout);
          chk("model_ovf",  bus.ovf,  expq[0].ovf);
          chk("model_zero", bus.zero, expq[0].zero);
          chk("model_neg",  bus.neg,  expq[0].neg);
          if (bus.out_ready) void'(expq.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) expq.push_back(model(bus.a, bus.b, bus.sub));
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_sum   = bus.sum;
    end
  end

  // Called at a drive point (posedge+1) with an empty pipeline and out_ready=1.
  task automatic send_check(input logic [31:0] xa, input logic [31:0] xb, input logic xs,
                            input logic [31:0] es, input logic ec, input logic eo,
                            input logic ez, input logic en, input string tag);
    bus.in_valid = 1'b1;
    bus.a = xa;
    bus.b = xb;
    bus.sub = xs;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_lat1_valid"}, bus.out_valid, 0);
    @(negedge clk);
    chk({tag, "_valid"}, bus.out_valid, 1);
    chk({tag, "_sum"},   bus.sum,  es);
    chk({tag, "_cout"},  bus.cout, ec);
    chk({tag, "_ovf"},   bus.ovf,  eo);
    chk({tag, "_zero"},  bus.zero, ez);
    chk({tag, "_neg"},   bus.neg,  en);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    while (expq.size() != 0 && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
    chk({tag, "_drained"}, expq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    res_t m;
    logic pat [8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    int acc, cyc;
    logic need_new;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;

    // Pin the model with hand-computed values.
    m = model(32'hFFFF_FFFF, 32'h1, 1'b0);
    chk("pin_wrap_sum", m.sum, 32'h0);
    chk("pin_wrap_cout", m.cout, 1);
    chk("pin_wrap_zero", m.zero, 1);
    m = model(32'h3, 32'h5, 1'b1);
    chk("pin_borrow_sum", m.sum, 32'hFFFF_FFFE);
    chk("pin_borrow_cout", m.cout, 0);
    m = model(32'h8000_0000, 32'h8000_0000, 1'b0);
    chk("pin_negovf_ovf", m.ovf, 1);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("post_reset_in_ready", bus.in_ready, 1);
    chk("post_reset_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;

    send_check(32'h0000_FFFF, 32'h1, 1'b0, 32'h0001_0000, 0, 0, 0, 0, "seg_carry");
    send_check(32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 0, 0, 0, 1, "sub_neg");
    send_check(32'd7, 32'd7, 1'b1, 32'h0, 1, 0, 1, 0, "sub_zero");
`ifdef PIPELINED_ADDSUB_SATURATE_EN
    send_check(32'h7FFF_FFFF, 32'h1, 1'b0, 32'h7FFF_FFFF, 0, 1, 0, 0, "pos_ovf");
    send_check(32'h8000_0000, 32'h1, 1'b1, 32'h8000_0000, 1, 1, 0, 1, "neg_ovf");
`else
    send_check(32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 0, 1, 0, 1, "pos_ovf");
    send_check(32'h8000_0000, 32'h1, 1'b1, 32'h7FFF_FFFF, 1, 1, 0, 0, "neg_ovf");
`endif

    // Asynchronous reset while a stalled result with nonzero flags is held.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.a = 32'd5;
    bus.b = 32'd7;
    bus.sub = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("pre_async_valid", bus.out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", bus.out_valid, 0);
    chk("async_rst_sum",   bus.sum, 0);
    chk("async_rst_flags", {bus.cout, bus.ovf, bus.zero, bus.neg}, 0);
    repeat (3) @(posedge clk);
    #4 rst = 1'b0;
    #1;
    chk("release_in_ready", bus.in_ready, 1);
    chk("release_out_valid", bus.out_valid, 0);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Eight back-to-back ops against a fixed out_ready pattern.
    acc = 0;
    cyc = 0;
    need_new = 1'b1;
    while (acc < 8 && cyc < 200) begin
      if (need_new) begin
        bus.a = pick();
        bus.b = pick();
        bus.sub = 1'($urandom_range(0, 1));
      end
      bus.in_valid = 1'b1;
      bus.out_ready = pat[cyc % 8];
      @(negedge clk);
      need_new = bus.in_ready;
      if (bus.in_ready) acc++;
      @(posedge clk);
      #1 cyc++;
    end
    chk("stream_accepted", acc, 8);
    bus.in_valid = 1'b0;
    while (expq.size() != 0 && cyc < 300) begin
      bus.out_ready = pat[cyc % 8];
      @(posedge clk);
      #1 cyc++;
    end
    chk("stream_drained", expq.size(), 0);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.a = pick();
      bus.b = pick();
      bus.sub = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    drain("random");
    @(posedge clk);
    #1;

    // Two ops in flight, then a one-cycle reset pulse discards them.
    bus.in_valid = 1'b1;
    bus.a = 32'h1111_1111;
    bus.b = 32'h2222_2222;
    bus.sub = 1'b0;
    @(posedge clk);
    #1 bus.a = 32'h0000_0009;
    bus.b = 32'h0000_0004;
    bus.sub = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    #1 rst = 1'b1;
    #1 chk("flight_rst_valid", bus.out_valid, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("flight_discarded", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;
    send_check(32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 0, 0, 0, 0, "after_rst");
    drain("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised successor to the team's 32-bit adder-subtractor.
- Width is generic. The carry chain is split into SEG_W-bit segments, and each segment gets its own pipeline stage.
- A valid/ready handshake is added on both input and output, plus status flags.
- Used as the integer add/sub unit in datapaths where a full-width ripple carry misses timing.

Parameters:
- WIDTH, 32, operand/result width in bits; must be an integer multiple of SEG_W.
- SEG_W, 16, bits added per pipeline stage; NSEG = WIDTH/SEG_W stages (NSEG >= 1).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset
- in_valid  input  1  operand word valid
- in_ready  output  1  block can accept operands this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- sub  input  1  0: a+b, 1: a-b (b inverted, carry-in = 1)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB (subtract: 1 = no borrow)
- ovf  output  1  two's-complement signed overflow
- zero  output  1  sum == 0
- neg  output  1  sum[WIDTH-1]

Interface rule (already decided): one clock; reset is asynchronous and active-high.

Behaviour:
- Reset: all stage valid bits, sum, cout, ovf, zero, neg and out_valid go to 0 immediately. in_ready = 1 once rst deasserts.
- Operand capture:
  - Transfer on in_valid && in_ready.
  - b is XORed with {WIDTH{sub}}; sub is the carry-in of segment 0.
- Stage k (0..NSEG-1):
  - Adds segment k of a and b^sub, plus the registered carry from stage k-1 (stage 0 uses sub).
  - Registers the SEG_W-bit partial sum and the carry.
  - Not-yet-added upper segments are delayed through skew registers. Completed lower segments are delayed through de-skew registers.
  - All segments of one operation emerge in the same cycle.
- Latency and throughput:
  - Latency = NSEG cycles from input transfer to out_valid; latency is 2 at default parameters.
  - Throughput 1 op/cycle.
  - NSEG = 1 degenerates to a single registered adder with latency 1.
- Stall:
  - stall = out_valid && !out_ready.
  - in_ready = !stall.
  - While stalled, every stage, skew register and output holds its value.
- Bubbles: when not stalled, the pipeline advances every cycle; empty stages carry valid = 0.
- Simultaneous events: out_valid && out_ready && in_valid in the same cycle retires the output and accepts a new op; there is no bubble.
- Flags, computed in the final stage from the full result:
  - cout = carry out of the top segment.
  - ovf = (a[MSB] == bx[MSB]) && (raw_sum[MSB] != a[MSB]), where bx = b^{WIDTH{sub}}; a[MSB] and bx[MSB] are carried down the pipeline.
  - zero and neg are derived from the final sum output.
- Flag timing: flags are valid only when out_valid = 1, and hold with sum during a stall.
- Ordering: results leave in input order; no drop or duplication.
- Reset mid-operation: in-flight ops are discarded; no result for them ever appears.
- Elaboration: WIDTH % SEG_W != 0 or SEG_W > WIDTH is a fatal elaboration error.

Optional Feature:
- Macro: PIPELINED_ADDSUB_SATURATE_EN.
- Defined:
  - On ovf, sum saturates to the signed limit in the direction of a's sign:
    - a[MSB] = 0 gives 0111…1;
    - a[MSB] = 1 gives 1000…0.
  - ovf still reports 1; zero and neg follow the saturated value; cout is unchanged.
  - Latency is unchanged: saturation is applied in the final stage.
- Not defined: sum wraps modulo 2^WIDTH; no extra logic.

Test Plan (WIDTH=32, SEG_W=16, latency 2):
1. Assert rst mid-cycle, hold 3 cycles -> out_valid=0, sum=0, all flags 0 asynchronously; in_ready=1 after release.
2. a=0x0000FFFF, b=0x00000001, sub=0 -> 2 cycles later sum=0x00010000, cout=0, ovf=0, zero=0, neg=0 (carry crosses segment boundary).
3. a=5, b=7, sub=1 -> sum=0xFFFFFFFE, cout=0, neg=1. Then a=7, b=7, sub=1 -> sum=0, zero=1, cout=1.
4. a=0x7FFFFFFF, b=1, sub=0 -> without macro: sum=0x80000000, ovf=1, neg=1. With macro: sum=0x7FFFFFFF, ovf=1, neg=0. Also a=0x80000000, b=1, sub=1 -> with macro sum=0x80000000, ovf=1.
5. Stream 8 back-to-back random ops; out_ready pattern 1,0,0,1,1,0,1,1,… -> all 8 results match the model in order; in_ready=0 exactly on stalled cycles; sum held during stall.
6. Two ops in flight, pulse rst for 1 cycle -> out_valid stays 0 afterwards; a new op after release returns a correct result 2 cycles later.
